// File: rtl/sdf_stage_controller.sv
// sdf_stage_controller
//   Sequencer for one SDF NTT/INTT pipeline stage (delay buffer + BFU +
//   in/out muxes). It counts an N-sample frame and drives the per-slot
//   controls, the output-valid strobe and the end-of-frame done pulse.
//
// Ports
//   clk                      clock, all logic on posedge
//   rst                      synchronous reset, active-high
//   start                    begin a frame (accepted only when idle)
//   mode                     0 = NTT, 1 = INTT, latched when start is accepted
//   in_valid                 stage input carries a sample this cycle
//   buffer_enable            delay-buffer shift enable
//   buffer_in_mux_selector   1 = load registered stage input, 0 = load BFU output 2
//   buffer_out_mux_selector  0 = output delay buffer, 1 = output BFU output 1
//   bfu_sel                  BFU mux-select bus
//   intt_logic_enable        latched mode while busy
//   tw_addr                  twiddle ROM address
//   out_valid                stage output holds a valid result
//   busy                     a frame is in progress
//   done                     one-cycle pulse at end of frame
module sdf_stage_controller #(
    parameter int         N        = 16,
    parameter int         LOGN     = 4,
    parameter int         INDEX    = 2,
    parameter int         BFU_LAT  = 0,
    parameter logic [5:0] NTT_SEL  = 6'b101010,
    parameter logic [5:0] INTT_SEL = 6'b010101
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic            in_valid,
    output logic            buffer_enable,
    output logic            buffer_in_mux_selector,
    output logic            buffer_out_mux_selector,
    output logic [5:0]      bfu_sel,
    output logic            intt_logic_enable,
    output logic [LOGN-2:0] tw_addr,
    output logic            out_valid,
    output logic            busy,
    output logic            done
);

    localparam int              D          = 1 << INDEX;
    localparam logic [LOGN-1:0] CNT_LAST   = LOGN'(N - 1);
    localparam logic [LOGN-1:0] FLUSH_LAST = LOGN'(D - 1);
    localparam logic [LOGN-1:0] TW_MASK    = LOGN'(D - 1);
    localparam int              TW_SHIFT   = LOGN - 1 - INDEX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t          state_q;
    logic [LOGN-1:0] cnt_q;
    logic [LOGN-1:0] flush_cnt_q;
    logic            mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
            mode_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        flush_cnt_q <= '0;
                        mode_q      <= mode;
                    end
                end
                S_RUN: begin
                    // The counter wraps to 0 on the last sample, leaving it clean
                    // for the next frame.
                    if (in_valid) begin
                        cnt_q <= cnt_q + LOGN'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + LOGN'(1);
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ---- p0: slot accepted this cycle (a valid input in RUN, or a flush slot)
    logic vld_p0;
    logic flush_p0;
    logic done_p0;

    assign vld_p0   = ((state_q == S_RUN) && in_valid) || (state_q == S_FLUSH);
    assign flush_p0 = (state_q == S_FLUSH);
    assign done_p0  = (state_q == S_DONE);

    // ---- p1: controls line up with the registered stage input
    logic            vld_p1;
    logic            flush_p1;
    logic            done_p1;
    logic [LOGN-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            flush_p1 <= 1'b0;
            done_p1  <= 1'b0;
            cnt_p1   <= '0;
        end else begin
            vld_p1   <= vld_p0;
            flush_p1 <= flush_p0;
            done_p1  <= done_p0;
            cnt_p1   <= cnt_q;
        end
    end

    logic ph_p1;
    logic fly_p1;
    logic fill_p1;
    logic ov_p1;

    assign ph_p1   = cnt_p1[INDEX];
    assign fly_p1  = vld_p1 && !flush_p1 && ph_p1;
    assign fill_p1 = vld_p1 && !flush_p1 && !ph_p1;

    // Every slot except the fill slots of the first group emits a result:
    // butterfly slots emit BFU output 1, later fill slots drain the buffer,
    // and flush slots drain the last group.
    assign ov_p1 = vld_p1 && (flush_p1 || ((cnt_p1 >> INDEX) != '0));

    assign buffer_enable           = vld_p1;
    assign buffer_in_mux_selector  = fill_p1;
    assign buffer_out_mux_selector = fly_p1;
    // The mask is empty when INDEX is 0, giving a constant zero address.
    assign tw_addr = fly_p1 ? (LOGN-1)'((cnt_p1 & TW_MASK) << TW_SHIFT) : '0;

    assign busy              = (state_q != S_IDLE);
    assign intt_logic_enable = busy && mode_q;
    assign bfu_sel           = busy ? (mode_q ? INTT_SEL : NTT_SEL) : 6'b000000;

    // ---- p2..: out_valid and done follow the BFU output latency
    generate
        if (BFU_LAT == 0) begin : g_no_lat
            assign out_valid = ov_p1;
            assign done      = done_p1;
        end else begin : g_lat
            logic [BFU_LAT-1:0] ov_sr;
            logic [BFU_LAT-1:0] done_sr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ov_sr   <= '0;
                    done_sr <= '0;
                end else begin
                    ov_sr[0]   <= ov_p1;
                    done_sr[0] <= done_p1;
                    for (int i = 1; i < BFU_LAT; i++) begin
                        ov_sr[i]   <= ov_sr[i-1];
                        done_sr[i] <= done_sr[i-1];
                    end
                end
            end

            assign out_valid = ov_sr[BFU_LAT-1];
            assign done      = done_sr[BFU_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_sdf_stage_controller.sv
module tb_sdf_stage_controller;

    localparam logic [5:0] NTT_S  = 6'b101010;
    localparam logic [5:0] INTT_S = 6'b010101;

    logic clk = 1'b0;
    logic rst, start, mode, in_valid;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Outputs of three builds: D=1 (u0), D=4 (u2), D=8 with BFU_LAT=2 (u3)
    logic       be0, im0, om0, intt0, ov0, busy0, done0;
    logic       be2, im2, om2, intt2, ov2, busy2, done2;
    logic       be3, im3, om3, intt3, ov3, busy3, done3;
    logic [5:0] sel0, sel2, sel3;
    logic [2:0] tw0, tw2, tw3;

    sdf_stage_controller #(.N(16), .LOGN(4), .INDEX(0), .BFU_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
        .buffer_enable(be0), .buffer_in_mux_selector(im0), .buffer_out_mux_selector(om0),
        .bfu_sel(sel0), .intt_logic_enable(intt0), .tw_addr(tw0),
        .out_valid(ov0), .busy(busy0), .done(done0));

    sdf_stage_controller #(.N(16), .LOGN(4), .INDEX(2), .BFU_LAT(0)) u2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
        .buffer_enable(be2), .buffer_in_mux_selector(im2), .buffer_out_mux_selector(om2),
        .bfu_sel(sel2), .intt_logic_enable(intt2), .tw_addr(tw2),
        .out_valid(ov2), .busy(busy2), .done(done2));

    sdf_stage_controller #(.N(16), .LOGN(4), .INDEX(3), .BFU_LAT(2)) u3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
        .buffer_enable(be3), .buffer_in_mux_selector(im3), .buffer_out_mux_selector(om3),
        .bfu_sel(sel3), .intt_logic_enable(intt3), .tw_addr(tw3),
        .out_valid(ov3), .busy(busy3), .done(done3));

    typedef struct packed {
        logic       in_m;
        logic       out_m;
        logic [2:0] tw;
        logic       ov;
    } exp_t;

    exp_t q0[$], q2[$], q3[$];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;
    bit exp_mode = 1'b0;

    int ov_cnt0, ov_cnt2, ov_cnt3;
    int done_cnt0, done_cnt2, done_cnt3;
    int first_ov0, first_ov2, first_ov3;
    int done_cyc2, first_iv, gap2;
    bit seen_be2;
    logic [19:0] pat2;
    logic [23:0] twl0, twl2, twl3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Expected per-slot controls for stage index idx, sample k (or a flush slot).
    function automatic exp_t mk(input int idx, input int k, input bit fl);
        exp_t e;
        int   d;
        bit   ph;
        d = 1 << idx;
        e = '0;
        if (fl) begin
            e.ov = 1'b1;
        end else begin
            ph      = ((k >> idx) & 1) != 0;
            e.in_m  = !ph;
            e.out_m = ph;
            e.tw    = (ph && idx > 0) ? 3'((k % d) << (3 - idx)) : 3'd0;
            e.ov    = (k >= d);
        end
        return e;
    endfunction

    // ---------------- monitors (scoreboard side) ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (be2) begin
                seen_be2 = 1'b1;
                chk("u2 pending slot", q2.size() > 0, 1'b1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    chk("u2 in_mux", im2, e.in_m);
                    chk("u2 out_mux", om2, e.out_m);
                    chk("u2 tw_addr", tw2, e.tw);
                    chk("u2 out_valid", ov2, e.ov);
                end
                pat2 = {pat2[18:0], im2};
                if (om2) twl2 = {twl2[20:0], tw2};
            end else begin
                chk("u2 out_valid without slot", ov2, 1'b0);
                if (busy2 && seen_be2) gap2++;
            end
            if (ov2) begin
                ov_cnt2++;
                if (first_ov2 < 0) first_ov2 = cyc;
            end
            if (done2) begin
                done_cnt2++;
                done_cyc2 = cyc;
            end
            chk("u2 bfu_sel", sel2, busy2 ? (exp_mode ? INTT_S : NTT_S) : 6'd0);
            chk("u2 intt_en", intt2, busy2 & exp_mode);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (be0) begin
                chk("u0 pending slot", q0.size() > 0, 1'b1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("u0 in_mux", im0, e.in_m);
                    chk("u0 out_mux", om0, e.out_m);
                    chk("u0 tw_addr", tw0, e.tw);
                    chk("u0 out_valid", ov0, e.ov);
                end
                if (om0) twl0 = {twl0[20:0], tw0};
            end else begin
                chk("u0 out_valid without slot", ov0, 1'b0);
            end
            if (ov0) begin
                ov_cnt0++;
                if (first_ov0 < 0) first_ov0 = cyc;
            end
            if (done0) done_cnt0++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (be3) begin
                chk("u3 pending slot", q3.size() > 0, 1'b1);
                if (q3.size() > 0) begin
                    e = q3.pop_front();
                    chk("u3 in_mux", im3, e.in_m);
                    chk("u3 out_mux", om3, e.out_m);
                    chk("u3 tw_addr", tw3, e.tw);
                end
                if (om3) twl3 = {twl3[20:0], tw3};
            end
            if (ov3) begin
                ov_cnt3++;
                if (first_ov3 < 0) first_ov3 = cyc;
            end
            if (done3) done_cnt3++;
            chk("u3 intt_en", intt3, busy3 & exp_mode);
        end
    end

    // ---------------- stimulus side ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input int k);
        q0.push_back(mk(0, k, 1'b0));
        q2.push_back(mk(2, k, 1'b0));
        q3.push_back(mk(3, k, 1'b0));
    endtask

    task automatic push_flush();
        q0.push_back(mk(0, 0, 1'b1));
        for (int i = 0; i < 4; i++) q2.push_back(mk(2, 0, 1'b1));
        for (int i = 0; i < 8; i++) q3.push_back(mk(3, 0, 1'b1));
    endtask

    task automatic clear_stats();
        ov_cnt0 = 0; ov_cnt2 = 0; ov_cnt3 = 0;
        done_cnt0 = 0; done_cnt2 = 0; done_cnt3 = 0;
        first_ov0 = -1; first_ov2 = -1; first_ov3 = -1;
        done_cyc2 = -1; gap2 = 0; seen_be2 = 1'b0;
        pat2 = '1; twl0 = '1; twl2 = '1; twl3 = '1;
    endtask

    task automatic run_frame(input bit m, input bit stalls, input bit tog,
                             input bit pulses, input string tag);
        int w;
        clear_stats();
        exp_mode = m;
        mode     = m;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (stalls && (k == 5 || k == 11)) begin
                in_valid = 1'b0;
                tick();
            end
            if (k == 0) first_iv = cyc;
            if (tog) mode = ~mode;
            start    = pulses && (k == 7);
            in_valid = 1'b1;
            push_sample(k);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        push_flush();
        if (pulses) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        w = 0;
        while ((busy0 || busy2 || busy3) && w < 100) begin
            tick();
            w++;
        end
        chk({tag, " frame ends idle"}, {busy0, busy2, busy3}, 3'b000);
        repeat (4) tick();

        chk({tag, " u0 out_valid count"}, ov_cnt0, 16);
        chk({tag, " u2 out_valid count"}, ov_cnt2, 16);
        chk({tag, " u3 out_valid count"}, ov_cnt3, 16);
        chk({tag, " u0 done count"}, done_cnt0, 1);
        chk({tag, " u2 done count"}, done_cnt2, 1);
        chk({tag, " u3 done count"}, done_cnt3, 1);
        chk({tag, " queues drained"}, q0.size() + q2.size() + q3.size(), 0);
        chk({tag, " u2 stall gap"}, gap2, stalls ? 2 : 0);
        chk({tag, " u2 in_mux pattern"}, pat2, 20'b1111_0000_1111_0000_0000);
        chk({tag, " u2 tw sequence"}, twl2, 24'o02460246);
        chk({tag, " u3 tw sequence"}, twl3, 24'o01234567);
        chk({tag, " u0 tw sequence"}, twl0, 24'o00000000);
        chk({tag, " u2 first out_valid latency"}, first_ov2 - first_iv, 5);
        chk({tag, " u0 first out_valid latency"}, first_ov0 - first_iv, 2);
        if (!stalls) begin
            chk({tag, " u2 done latency"}, done_cyc2 - first_iv, 21);
            chk({tag, " u3 first out_valid latency"}, first_ov3 - first_iv, 11);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        clear_stats();
        repeat (3) tick();
        @(negedge clk);
        chk("reset u0 outputs", {be0, im0, om0, sel0, intt0, tw0, ov0, busy0, done0}, 0);
        chk("reset u2 outputs", {be2, im2, om2, sel2, intt2, tw2, ov2, busy2, done2}, 0);
        chk("reset u3 outputs", {be3, im3, om3, sel3, intt3, tw3, ov3, busy3, done3}, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        run_frame(1'b0, 1'b0, 1'b0, 1'b0, "ntt plain");
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, "ntt stalls");
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, "intt mode toggle");

        // Abort a frame with reset while sample 9 is presented.
        clear_stats();
        exp_mode = 1'b1;
        mode     = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            push_sample(k);
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort u0 outputs", {be0, im0, om0, sel0, intt0, tw0, ov0, busy0, done0}, 0);
        chk("abort u2 outputs", {be2, im2, om2, sel2, intt2, tw2, ov2, busy2, done2}, 0);
        chk("abort u3 outputs", {be3, im3, om3, sel3, intt3, tw3, ov3, busy3, done3}, 0);
        tick();
        chk("abort queues drained", q0.size() + q2.size() + q3.size(), 0);
        repeat (3) tick();

        run_frame(1'b0, 1'b0, 1'b0, 1'b0, "after abort");
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, "start pulses");

        repeat (20) tick();
        chk("no extra frame busy", {busy0, busy2, busy3}, 3'b000);
        chk("no extra done u2", done_cnt2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
